// File: rtl/addsub_pkg.sv
// Shared types for the pipelined CLA adder/subtractor.
//   addsub_op_e    : operation select (value 3 is reserved and behaves as OP_ADD)
//   addsub_flags_t : result flags {c, v, z, n}
//   op_carry_in    : carry into bit 0 for a given operation
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ADC = 2'd2
    } addsub_op_e;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } addsub_flags_t;

    // Subtract is a + ~b + 1, so the "+1" enters as the block-0 carry-in.
    function automatic logic op_carry_in(input logic [1:0] op, input logic carry);
        logic cin;
        case (op)
            OP_SUB:  cin = 1'b1;
            OP_ADC:  cin = carry;
            default: cin = 1'b0;
        endcase
        return cin;
    endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle of the pipelined CLA adder/subtractor.
//   valid_i/ready_o, a_i, b_i, op_i, carry_i : input op channel
//   valid_o/ready_i, sum_o, flags_o          : result channel
//   master : producer of ops and consumer of results (the environment)
//   slave  : the arithmetic unit
interface cla_addsub_pipe_if #(
    parameter int Width = 32
);
    import addsub_pkg::*;

    logic                 valid_i;
    logic                 ready_o;
    logic [Width-1:0]     a_i;
    logic [Width-1:0]     b_i;
    logic [1:0]           op_i;
    logic                 carry_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [Width-1:0]     sum_o;
    addsub_flags_t        flags_o;

    modport master (
        output valid_i, a_i, b_i, op_i, carry_i, ready_i,
        input  ready_o, valid_o, sum_o, flags_o
    );

    modport slave (
        input  valid_i, a_i, b_i, op_i, carry_i, ready_i,
        output ready_o, valid_o, sum_o, flags_o
    );

endinterface

// File: rtl/cla_block.sv
// Combinational carry-lookahead block.
//   a, b   : operand bits (b already conditioned, i.e. inverted for subtract)
//   cin    : carry into bit 0
//   sum    : block sum
//   blk_p  : block propagate (all bits propagate)
//   blk_g  : block generate (block produces a carry on its own)
module cla_block #(
    parameter int BlockWidth = 8
) (
    input  logic [BlockWidth-1:0] a,
    input  logic [BlockWidth-1:0] b,
    input  logic                  cin,
    output logic [BlockWidth-1:0] sum,
    output logic                  blk_p,
    output logic                  blk_g
);

    logic [BlockWidth-1:0] g_s;
    logic [BlockWidth-1:0] p_s;
    logic [BlockWidth-1:0] c_s;

    assign g_s = a & b;
    assign p_s = a | b;

    // Every carry is a flat OR of generate terms gated by the propagate chain below them.
    always_comb begin
        logic acc;
        logic prod;
        acc  = 1'b0;
        prod = 1'b1;
        c_s  = {BlockWidth{1'b0}};
        for (int i = 0; i < BlockWidth; i++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g_s[j]);
                prod = prod & p_s[j];
            end
            c_s[i] = acc | (prod & cin);
        end
    end

    // Block-level generate/propagate, independent of cin.
    always_comb begin
        logic gacc;
        logic pacc;
        gacc = 1'b0;
        pacc = 1'b1;
        for (int j = BlockWidth - 1; j >= 0; j--) begin
            gacc = gacc | (pacc & g_s[j]);
            pacc = pacc & p_s[j];
        end
        blk_g = gacc;
        blk_p = pacc;
    end

    assign sum = a ^ b ^ c_s;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one BlockWidth-bit block per stage.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   flush_i : synchronous clear of all in-flight ops
//   bus     : slave side of cla_addsub_pipe_if (ops in, results + flags out)
// Stage k registers the partial sum (bits below (k+1)*BlockWidth), the still
// unresolved operand bits shifted down to bit 0, the block carry-out and the
// running zero flag. The final stage drives the outputs.
module cla_addsub_pipe
    import addsub_pkg::*;
#(
    parameter int Width      = 32,
    parameter int BlockWidth = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    cla_addsub_pipe_if.slave   bus
);

    localparam int NumStages = Width / BlockWidth;
    localparam int Last      = NumStages - 1;

    if ((BlockWidth < 1) || ((Width % BlockWidth) != 0)) begin : g_width_check
        $error("cla_addsub_pipe: Width must be a positive multiple of BlockWidth");
    end

    // Handshake chain: load_s[NumStages] is the downstream ready.
    logic [NumStages:0]    load_s;
    logic [NumStages-1:0]  load_en_s;
    logic                  ready_s;

    // Per-stage combinational inputs (what the stage would capture this edge).
    logic [Width-1:0]      src_a_s   [NumStages];
    logic [Width-1:0]      src_b_s   [NumStages];
    logic [Width-1:0]      src_sum_s [NumStages];
    logic [NumStages-1:0]  src_valid_s;
    logic [NumStages-1:0]  src_cin_s;
    logic [NumStages-1:0]  src_z_s;

    // Per-stage block results.
    logic [BlockWidth-1:0] blk_sum_s [NumStages];
    logic [NumStages-1:0]  blk_p_s;
    logic [NumStages-1:0]  blk_g_s;
    logic [NumStages-1:0]  cout_s;

    // Stage registers.
    logic [NumStages-1:0]  valid_r;
    logic [Width-1:0]      a_r   [NumStages];
    logic [Width-1:0]      b_r   [NumStages];
    logic [Width-1:0]      sum_r [NumStages];
    logic [NumStages-1:0]  carry_r;
    logic [NumStages-1:0]  z_r;
    addsub_flags_t         flags_r;
    addsub_flags_t         flags_s;

    logic                  sub_s;
    logic [Width-1:0]      b_inv_s;

    // Stage-0 operand conditioning: B is inverted for subtract.
    always_comb begin
        sub_s   = (bus.op_i == OP_SUB);
        b_inv_s = bus.b_i ^ {Width{sub_s}};
    end

    // Advance rule evaluated from the output back: a stage loads if empty or if its successor loads.
    always_comb begin
        load_s            = {(NumStages + 1){1'b0}};
        load_s[NumStages] = bus.ready_i;
        for (int k = NumStages - 1; k >= 0; k--) begin
            load_s[k] = ~valid_r[k] | load_s[k + 1];
        end
    end

    assign ready_s     = load_s[0] & ~flush_i;
    assign bus.ready_o = ready_s;

    for (genvar k = 0; k < NumStages; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign src_a_s[k]     = bus.a_i;
            assign src_b_s[k]     = b_inv_s;
            assign src_sum_s[k]   = {Width{1'b0}};
            assign src_valid_s[k] = bus.valid_i & ready_s;
            assign src_cin_s[k]   = op_carry_in(bus.op_i, bus.carry_i);
            assign src_z_s[k]     = 1'b1;
        end else begin : g_src
            assign src_a_s[k]     = a_r[k - 1];
            assign src_b_s[k]     = b_r[k - 1];
            assign src_sum_s[k]   = sum_r[k - 1];
            assign src_valid_s[k] = valid_r[k - 1];
            assign src_cin_s[k]   = carry_r[k - 1];
            assign src_z_s[k]     = z_r[k - 1];
        end

        cla_block #(
            .BlockWidth (BlockWidth)
        ) u_cla (
            .a     (src_a_s[k][BlockWidth-1:0]),
            .b     (src_b_s[k][BlockWidth-1:0]),
            .cin   (src_cin_s[k]),
            .sum   (blk_sum_s[k]),
            .blk_p (blk_p_s[k]),
            .blk_g (blk_g_s[k])
        );

        // Block carry-out comes from block P/G, not from the bit-level carries.
        assign cout_s[k]    = blk_g_s[k] | (blk_p_s[k] & src_cin_s[k]);
        // Data only moves when a real op moves, so held outputs survive bubbles and flushes.
        assign load_en_s[k] = load_s[k] & src_valid_s[k] & ~flush_i;
    end

    // Flags are derived while the top block is resolved so they register with the sum.
    always_comb begin
        flags_s   = addsub_flags_t'(4'b0000);
        flags_s.c = cout_s[Last];
        flags_s.v = (src_a_s[Last][BlockWidth-1] == src_b_s[Last][BlockWidth-1]) &
                    (blk_sum_s[Last][BlockWidth-1] != src_a_s[Last][BlockWidth-1]);
        flags_s.z = src_z_s[Last] & (blk_sum_s[Last] == {BlockWidth{1'b0}});
        flags_s.n = blk_sum_s[Last][BlockWidth-1];
    end

    // Stage registers: valid bits follow the advance rule, payload follows real ops only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumStages; k++) begin
                valid_r[k] <= 1'b0;
                a_r[k]     <= {Width{1'b0}};
                b_r[k]     <= {Width{1'b0}};
                sum_r[k]   <= {Width{1'b0}};
                carry_r[k] <= 1'b0;
                z_r[k]     <= 1'b0;
            end
            flags_r <= addsub_flags_t'(4'b0000);
        end else begin
            for (int k = 0; k < NumStages; k++) begin
                if (flush_i) begin
                    valid_r[k] <= 1'b0;
                end else if (load_s[k]) begin
                    valid_r[k] <= src_valid_s[k];
                end else begin
                    valid_r[k] <= valid_r[k];
                end
                if (load_en_s[k]) begin
                    a_r[k]     <= src_a_s[k] >> BlockWidth;
                    b_r[k]     <= src_b_s[k] >> BlockWidth;
                    sum_r[k]   <= src_sum_s[k] | (Width'(blk_sum_s[k]) << (k * BlockWidth));
                    carry_r[k] <= cout_s[k];
                    z_r[k]     <= src_z_s[k] & (blk_sum_s[k] == {BlockWidth{1'b0}});
                end else begin
                    a_r[k]     <= a_r[k];
                    b_r[k]     <= b_r[k];
                    sum_r[k]   <= sum_r[k];
                    carry_r[k] <= carry_r[k];
                    z_r[k]     <= z_r[k];
                end
            end
            if (load_en_s[Last]) begin
                flags_r <= flags_s;
            end else begin
                flags_r <= flags_r;
            end
        end
    end

    assign bus.valid_o = valid_r[Last];
    assign bus.sum_o   = sum_r[Last];
    assign bus.flags_o = flags_r;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe (Width=32, BlockWidth=8).
// The driver pushes hand-computed {sum, flags} on each accepted op; an
// independent monitor pops and compares on every result transfer and checks
// that a stalled result stays stable.
module tb_cla_addsub_pipe;
    import addsub_pkg::*;

    localparam int Width      = 32;
    localparam int BlockWidth = 8;
    localparam int NumStages  = Width / BlockWidth;

    logic clk     = 1'b0;
    logic rst_ni  = 1'b0;
    logic flush_i = 1'b0;

    cla_addsub_pipe_if #(.Width(Width)) bus();

    cla_addsub_pipe #(
        .Width      (Width),
        .BlockWidth (BlockWidth)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int errors     = 0;
    int out_count  = 0;
    int ready_mode = 0;
    logic [35:0] exp_q[$];
    logic [31:0] last_sum = 32'h0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = pattern 1,0,0,1,0,1,1,0, else stalled.
    initial begin
        logic [7:0] pat;
        int pidx;
        pat  = 8'b0110_1001;
        pidx = 0;
        bus.ready_i = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: bus.ready_i = 1'b1;
                1: begin
                    bus.ready_i = pat[pidx];
                    pidx = (pidx + 1) % 8;
                end
                default: bus.ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: compare each transferred result, and check held results stay put.
    initial begin
        logic        held;
        logic [35:0] held_val;
        logic [35:0] exp;
        held     = 1'b0;
        held_val = 36'h0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_ni) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid_o", {63'h0, bus.valid_o}, 64'h1);
                    check("hold_result", {28'h0, bus.sum_o, bus.flags_o}, {28'h0, held_val});
                end
                if (bus.valid_o && bus.ready_i) begin
                    out_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output got=%0h/%0h expected=none",
                                 bus.sum_o, bus.flags_o);
                    end else begin
                        exp = exp_q.pop_front();
                        check("result", {28'h0, bus.sum_o, bus.flags_o}, {28'h0, exp});
                        last_sum = exp[35:4];
                    end
                    held = 1'b0;
                end else if (bus.valid_o) begin
                    held     = 1'b1;
                    held_val = {bus.sum_o, bus.flags_o};
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [35:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.carry_i = cin;
        #1;
        while (!bus.ready_o && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (bus.ready_o) begin
            exp_q.push_back(exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=ready_o=0 expected=ready_o=1");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid_i = 1'b0;
        end
    endtask

    initial begin
        int lat;
        int base;
        bus.valid_i = 1'b0;
        bus.a_i     = 32'h0;
        bus.b_i     = 32'h0;
        bus.op_i    = 2'd0;
        bus.carry_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("rst_valid_o", {63'h0, bus.valid_o}, 64'h0);
        check("rst_ready_o", {63'h0, bus.ready_o}, 64'h1);
        check("rst_sum_o", {32'h0, bus.sum_o}, 64'h0);
        check("rst_flags_o", {60'h0, bus.flags_o}, 64'h0);

        // Carry rippling across all blocks, plus latency
        send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 4'b1010});
        lat = 0;
        do begin
            @(negedge clk);
            bus.valid_i = 1'b0;
            lat++;
        end while (!bus.valid_o && lat < 20);
        check("latency", 64'(lat), 64'(NumStages));
        idle(2);

        // Directed vectors, back to back
        send(OP_SUB, 32'h0000_0005, 32'h0000_0007, 1'b0, {32'hFFFF_FFFE, 4'b0001});
        send(OP_SUB, 32'h0000_0007, 32'h0000_0007, 1'b0, {32'h0000_0000, 4'b1010});
        send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 4'b0101});
        send(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, {32'h7FFF_FFFF, 4'b1100});
        send(OP_ADC, 32'h0000_FFFF, 32'h0000_0000, 1'b1, {32'h0001_0000, 4'b0000});
        send(OP_ADD, 32'h0000_FFFF, 32'h0000_0000, 1'b1, {32'h0000_FFFF, 4'b0000});
        idle(8);

        // Ten back-to-back ops under a stalling downstream
        #3;
        ready_mode = 1;
        send(OP_ADD, 32'h0000_0001, 32'h0000_0002, 1'b0, {32'h0000_0003, 4'b0000});
        send(OP_SUB, 32'h0000_0010, 32'h0000_0001, 1'b0, {32'h0000_000F, 4'b1000});
        send(OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0, {32'h2345_6789, 4'b0000});
        send(OP_ADC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {32'h0000_0000, 4'b1010});
        send(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, {32'hFFFF_FFFF, 4'b0001});
        send(OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, {32'h0000_0000, 4'b1110});
        send(2'd3,   32'h0000_0005, 32'h0000_0003, 1'b1, {32'h0000_0008, 4'b0000});
        send(OP_ADC, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, {32'h0000_0000, 4'b1010});
        send(OP_SUB, 32'h0000_0100, 32'h0000_0100, 1'b0, {32'h0000_0000, 4'b1010});
        send(OP_ADD, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, {32'hFFFF_FFFF, 4'b0001});
        idle(40);
        #3;
        ready_mode = 0;
        idle(4);
        check("stall_all_delivered", 64'(exp_q.size()), 64'h0);

        // Flush with an op offered in the same cycle
        #3;
        ready_mode = 2;
        idle(2);
        send(OP_ADD, 32'h0000_0011, 32'h0000_0022, 1'b0, {32'h0000_0033, 4'b0000});
        send(OP_ADD, 32'h0000_0044, 32'h0000_0055, 1'b0, {32'h0000_0099, 4'b0000});
        send(OP_SUB, 32'h0000_0066, 32'h0000_0006, 1'b0, {32'h0000_0060, 4'b1000});
        @(negedge clk);
        flush_i     = 1'b1;
        bus.valid_i = 1'b1;
        bus.op_i    = OP_ADD;
        bus.a_i     = 32'h0000_0123;
        bus.b_i     = 32'h0000_0001;
        #1;
        check("flush_ready_o", {63'h0, bus.ready_o}, 64'h0);
        check("flush_keeps_sum", {32'h0, bus.sum_o}, {32'h0, last_sum});
        exp_q.delete();
        #2;
        ready_mode = 0;
        @(negedge clk);
        flush_i     = 1'b0;
        bus.valid_i = 1'b0;
        base = out_count;
        idle(10);
        check("flush_no_output", 64'(out_count), 64'(base));
        check("flush_valid_o", {63'h0, bus.valid_o}, 64'h0);
        check("flush_sum_kept", {32'h0, bus.sum_o}, {32'h0, last_sum});

        // Reset while the pipe is full and stalled
        #3;
        ready_mode = 2;
        idle(2);
        send(OP_ADD, 32'h0000_0001, 32'h0000_0001, 1'b0, {32'h0000_0002, 4'b0000});
        send(OP_ADD, 32'h0000_0002, 32'h0000_0002, 1'b0, {32'h0000_0004, 4'b0000});
        send(OP_ADD, 32'h0000_0003, 32'h0000_0003, 1'b0, {32'h0000_0006, 4'b0000});
        send(OP_ADD, 32'h0000_0004, 32'h0000_0004, 1'b0, {32'h0000_0008, 4'b0000});
        @(negedge clk);
        bus.valid_i = 1'b0;
        check("full_valid_o", {63'h0, bus.valid_o}, 64'h1);
        #3;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_valid_o", {63'h0, bus.valid_o}, 64'h0);
        check("rst_mid_sum_o", {32'h0, bus.sum_o}, 64'h0);
        check("rst_mid_flags_o", {60'h0, bus.flags_o}, 64'h0);
        exp_q.delete();
        ready_mode = 0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("rst_rel_ready_o", {63'h0, bus.ready_o}, 64'h1);
        base = out_count;
        idle(10);
        check("rst_no_output", 64'(out_count), 64'(base));
        check("rst_valid_o_after", {63'h0, bus.valid_o}, 64'h0);

        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
